// File: rtl/exa_crosb_output_vc_arbiter.sv
// Per-output-port VC allocator: grants one (VC, input) pair per cycle, tracks VC busy/owner,
// gates allocation on credit. Define EXA_CROSB_VCALLOC_STRICT_PRIO_EN for strict class priority.
module exa_crosb_output_vc_arbiter #(
  parameter int in_num    = 4,
  parameter int prio_num  = 2,
  parameter int vc_num    = 2,
  parameter int logVcPrio = $clog2(prio_num*vc_num),
  parameter int logIn     = $clog2(in_num)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [in_num-1:0]             i_req,
  input  logic [in_num*logVcPrio-1:0]   i_req_vc,
  input  logic [prio_num*vc_num-1:0]    i_credit_avail,
  input  logic [prio_num*vc_num-1:0]    i_release,
  output logic [in_num-1:0]             o_grant,
  output logic [logVcPrio-1:0]          o_grant_vc,
  output logic [prio_num*vc_num-1:0]    o_vc_busy,
  output logic [prio_num*vc_num*logIn-1:0] o_vc_owner,
  output logic                          o_err_release
);
  localparam int VCS = prio_num*vc_num;

  logic [VCS-1:0][in_num-1:0] req_for;
  logic [VCS-1:0]             elig;
  logic [VCS-1:0]             busy;
  logic [VCS-1:0][logIn-1:0]  owner;
  logic [VCS-1:0][logIn-1:0]  in_ptr;
  logic                       vc_found;
  logic [logVcPrio-1:0]       sel_vc;
  logic [logIn-1:0]           sel_in;

  always_comb begin
    for (int v = 0; v < VCS; v++) begin
      for (int k = 0; k < in_num; k++)
        req_for[v][k] = i_req[k] && (i_req_vc[k*logVcPrio +: logVcPrio] == logVcPrio'(v));
      elig[v] = !busy[v] && i_credit_avail[v] && (|req_for[v]);
    end
  end

`ifdef EXA_CROSB_VCALLOC_STRICT_PRIO_EN
  localparam int LVC = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int LP  = (prio_num > 1) ? $clog2(prio_num) : 1;
  logic [prio_num-1:0][LVC-1:0] cls_ptr;
  logic [LP-1:0]                sel_cls;

  // Highest class with any eligible VC wins; round-robin inside that class.
  always_comb begin
    int idx;
    idx = 0;
    vc_found = 1'b0;
    sel_vc = '0;
    sel_cls = '0;
    for (int p = prio_num-1; p >= 0; p--) begin
      for (int i = 0; i < vc_num; i++) begin
        idx = p*vc_num + (int'(cls_ptr[p]) + i) % vc_num;
        if (!vc_found && elig[idx]) begin
          vc_found = 1'b1;
          sel_vc = logVcPrio'(idx);
          sel_cls = LP'(p);
        end
      end
    end
  end
`else
  logic [logVcPrio-1:0] vc_ptr;

  always_comb begin
    int idx;
    idx = 0;
    vc_found = 1'b0;
    sel_vc = '0;
    for (int i = 0; i < VCS; i++) begin
      idx = (int'(vc_ptr) + i) % VCS;
      if (!vc_found && elig[idx]) begin
        vc_found = 1'b1;
        sel_vc = logVcPrio'(idx);
      end
    end
  end
`endif

  // Winning VC always has at least one requester, so this search always hits when vc_found.
  always_comb begin
    int k;
    logic hit;
    k = 0;
    hit = 1'b0;
    sel_in = '0;
    for (int i = 0; i < in_num; i++) begin
      k = (int'(in_ptr[sel_vc]) + i) % in_num;
      if (!hit && req_for[sel_vc][k]) begin
        hit = 1'b1;
        sel_in = logIn'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_grant       <= '0;
      o_grant_vc    <= '0;
      o_err_release <= 1'b0;
      busy          <= '0;
      owner         <= '0;
      in_ptr        <= '0;
`ifdef EXA_CROSB_VCALLOC_STRICT_PRIO_EN
      cls_ptr       <= '0;
`else
      vc_ptr        <= '0;
`endif
    end else begin
      o_grant       <= '0;
      o_err_release <= |(i_release & ~busy);
      // A granted VC is never busy, so set and clear cannot collide on one bit.
      busy          <= busy & ~i_release;
      if (vc_found) begin
        o_grant[sel_in] <= 1'b1;
        o_grant_vc      <= sel_vc;
        busy[sel_vc]    <= 1'b1;
        owner[sel_vc]   <= sel_in;
        in_ptr[sel_vc]  <= logIn'((int'(sel_in) + 1) % in_num);
`ifdef EXA_CROSB_VCALLOC_STRICT_PRIO_EN
        cls_ptr[sel_cls] <= LVC'((int'(sel_vc) - int'(sel_cls)*vc_num + 1) % vc_num);
`else
        vc_ptr <= logVcPrio'((int'(sel_vc) + 1) % VCS);
`endif
      end
    end
  end

  assign o_vc_busy  = busy;
  assign o_vc_owner = owner;
endmodule

// File: tb/tb_exa_crosb_output_vc_arbiter.sv
// Directed bench for exa_crosb_output_vc_arbiter (4 inputs, 2 classes x 2 VCs).
module tb_exa_crosb_output_vc_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_req;
  logic [7:0] i_req_vc;
  logic [3:0] i_credit_avail;
  logic [3:0] i_release;
  logic [3:0] o_grant;
  logic [1:0] o_grant_vc;
  logic [3:0] o_vc_busy;
  logic [7:0] o_vc_owner;
  logic       o_err_release;
  int n_cmp = 0;
  int n_fail = 0;

  exa_crosb_output_vc_arbiter dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_req_vc(i_req_vc),
    .i_credit_avail(i_credit_avail), .i_release(i_release),
    .o_grant(o_grant), .o_grant_vc(o_grant_vc), .o_vc_busy(o_vc_busy),
    .o_vc_owner(o_vc_owner), .o_err_release(o_err_release)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_req = '0; i_req_vc = '0; i_credit_avail = '0; i_release = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (o_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    n_cmp++; if (o_vc_busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", o_vc_busy); end
    n_cmp++; if (o_err_release !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err_release); end
    n_cmp++; if (o_vc_owner !== 8'h0) begin n_fail++; $display("FAIL reset_owner: got %h want 00", o_vc_owner); end
  endtask

  task automatic test_single_grant;
    i_credit_avail = 4'hF;
    i_req = 4'b0001; i_req_vc[1:0] = 2'd2;
    tick();
    n_cmp++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", o_grant); end
    n_cmp++; if (o_grant_vc !== 2'd2) begin n_fail++; $display("FAIL single_grant_vc: got %0d want 2", o_grant_vc); end
    n_cmp++; if (o_vc_busy !== 4'b0100) begin n_fail++; $display("FAIL single_busy: got %b want 0100", o_vc_busy); end
    n_cmp++; if (o_vc_owner[5:4] !== 2'd0) begin n_fail++; $display("FAIL single_owner: got %0d want 0", o_vc_owner[5:4]); end
    // request left high for one more cycle must not regrant a busy VC
    tick();
    n_cmp++; if (o_grant !== 4'b0) begin n_fail++; $display("FAIL no_double_grant: got %b want 0000", o_grant); end
    i_req = '0; i_release = 4'b0100;
    tick();
    i_release = '0;
    n_cmp++; if (o_vc_busy !== 4'b0 || o_err_release !== 1'b0) begin n_fail++; $display("FAIL single_release: busy %b err %b want 0000 0", o_vc_busy, o_err_release); end
  endtask

  task automatic test_input_rr;
    logic [3:0] reqs [4];
    logic [3:0] exps [4];
    reqs = '{4'b1011, 4'b1010, 4'b1000, 4'b1011};
    exps = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    i_req_vc = 8'b01_01_01_01;
    for (int i = 0; i < 4; i++) begin
      i_req = reqs[i];
      tick();
      n_cmp++; if (o_grant !== exps[i] || o_grant_vc !== 2'd1) begin n_fail++; $display("FAIL rr_grant%0d: got %b vc %0d want %b vc 1", i, o_grant, o_grant_vc, exps[i]); end
      i_req = '0; i_release = 4'b0010;
      tick();
      i_release = '0;
      n_cmp++; if (o_vc_busy[1] !== 1'b0) begin n_fail++; $display("FAIL rr_release%0d: got %b want 0", i, o_vc_busy[1]); end
    end
  endtask

  task automatic test_credit_gate;
    logic [3:0] seen;
    i_credit_avail = 4'b0111;
    i_req_vc[5:4] = 2'd3; i_req = 4'b0100;
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= o_grant;
    end
    n_cmp++; if (seen !== 4'b0) begin n_fail++; $display("FAIL credit_block: got %b want 0000", seen); end
    i_credit_avail = 4'hF;
    tick();
    n_cmp++; if (o_grant !== 4'b0100 || o_grant_vc !== 2'd3) begin n_fail++; $display("FAIL credit_grant: got %b vc %0d want 0100 vc 3", o_grant, o_grant_vc); end
    i_req = '0; i_credit_avail = 4'b0111;
    tick();
    n_cmp++; if (o_vc_busy !== 4'b1000) begin n_fail++; $display("FAIL credit_loss_keeps_busy: got %b want 1000", o_vc_busy); end
    i_credit_avail = 4'hF; i_release = 4'b1000;
    tick();
    i_release = '0;
    n_cmp++; if (o_vc_busy !== 4'b0) begin n_fail++; $display("FAIL credit_release: got %b want 0000", o_vc_busy); end
  endtask

  task automatic test_release_collision;
    i_req_vc = '0; i_req = 4'b0010;
    tick();
    n_cmp++; if (o_grant !== 4'b0010 || o_grant_vc !== 2'd0) begin n_fail++; $display("FAIL coll_first: got %b vc %0d want 0010 vc 0", o_grant, o_grant_vc); end
    i_req = '0;
    tick();
    i_req = 4'b0100; i_release = 4'b0001;
    tick();
    i_release = '0;
    n_cmp++; if (o_grant !== 4'b0) begin n_fail++; $display("FAIL coll_same_cycle: got %b want 0000", o_grant); end
    tick();
    n_cmp++; if (o_grant !== 4'b0100 || o_grant_vc !== 2'd0) begin n_fail++; $display("FAIL coll_regrant: got %b vc %0d want 0100 vc 0", o_grant, o_grant_vc); end
    n_cmp++; if (o_vc_owner[1:0] !== 2'd2) begin n_fail++; $display("FAIL coll_owner: got %0d want 2", o_vc_owner[1:0]); end
    i_req = '0; i_release = 4'b1000;
    tick();
    i_release = '0;
    n_cmp++; if (o_err_release !== 1'b1 || o_vc_busy !== 4'b0001) begin n_fail++; $display("FAIL err_release: err %b busy %b want 1 0001", o_err_release, o_vc_busy); end
    tick();
    n_cmp++; if (o_err_release !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", o_err_release); end
  endtask

  task automatic test_vc_select;
    logic [3:0] e1, e2;
    logic [1:0] v1, v2;
`ifdef EXA_CROSB_VCALLOC_STRICT_PRIO_EN
    e1 = 4'b0010; v1 = 2'd3; e2 = 4'b0001; v2 = 2'd0;
`else
    e1 = 4'b0001; v1 = 2'd0; e2 = 4'b0010; v2 = 2'd3;
`endif
    // async reset with vc0 still busy frees it without waiting for a clock
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (o_vc_busy !== 4'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0000", o_vc_busy); end
    tick();
    reset = 1'b0;
    i_req_vc = 8'b00_00_11_00; i_req = 4'b0011;
    tick();
    n_cmp++; if (o_grant !== e1 || o_grant_vc !== v1) begin n_fail++; $display("FAIL vcsel_first: got %b vc %0d want %b vc %0d", o_grant, o_grant_vc, e1, v1); end
    i_req = i_req & ~e1;
    tick();
    n_cmp++; if (o_grant !== e2 || o_grant_vc !== v2) begin n_fail++; $display("FAIL vcsel_second: got %b vc %0d want %b vc %0d", o_grant, o_grant_vc, e2, v2); end
    i_req = '0;
    tick();
    n_cmp++; if (o_grant !== 4'b0 || o_grant_vc !== v2 || o_vc_busy !== 4'b1001) begin n_fail++; $display("FAIL vcsel_idle: got %b vc %0d busy %b want 0000 vc %0d 1001", o_grant, o_grant_vc, o_vc_busy, v2); end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_input_rr();
    test_credit_gate();
    test_release_collision();
    test_vc_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
